sr_latch_ctrl: RTL

//  Synchronous sequencer for one cross-coupled NOR SR latch. Arbitrates set/clear

---
 rtl/sr_ctrl_pkg.sv | 23 ++
 rtl/sr_fb_sync.sv | 22 ++
 rtl/sr_latch_ctrl.sv | 137 +++++++++++++
 3 files changed

// File: rtl/sr_ctrl_pkg.sv
// Shared types and constants for the SR latch sequencer.
package sr_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_DRIVE = 3'd1,
      ST_GUARD = 3'd2,
      ST_CHECK = 3'd3,
      ST_FAULT = 3'd4
   } state_t;

   localparam logic GRANT_SET = 1'b1;
   localparam logic GRANT_CLR = 1'b0;

   // Expected {q, q_bar} once the latch has settled after an operation.
   localparam logic [1:0] FB_EXP_SET = 2'b10;
   localparam logic [1:0] FB_EXP_CLR = 2'b01;

   function automatic logic [1:0] fb_expected(input logic grant);
      return (grant == GRANT_SET) ? FB_EXP_SET : FB_EXP_CLR;
   endfunction

endpackage

// File: rtl/sr_fb_sync.sv
// Two-flop synchroniser for the asynchronous latch q/q_bar feedback.
module sr_fb_sync (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] d,
   output logic [1:0] q
);

   logic [1:0] meta;

   // Both stages clear on reset so a stale level never reaches the checker.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         meta <= 2'b00;
         q    <= 2'b00;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/sr_latch_ctrl.sv
// Sequencer for one cross-coupled NOR SR latch: arbitrates set/clear
// requests, pulses s or r, waits out a guard time, then verifies feedback.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ST_IDLE  | waiting for a request; round-robin arbitration on ties
// ST_DRIVE | granted output (s or r) held high for PULSE_CYC cycles
// ST_GUARD | s=r=0 for GUARD_CYC cycles while feedback settles/synchronises
// ST_CHECK | one cycle: compare synchronised feedback, ack on match
// ST_FAULT | feedback mismatch seen; outputs parked until err_clr
module sr_latch_ctrl
   import sr_ctrl_pkg::*;
#(
   parameter int unsigned PULSE_CYC = 2,
   parameter int unsigned GUARD_CYC = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic set_req,
   input  logic clr_req,
   input  logic err_clr,
   input  logic q_fb,
   input  logic q_bar_fb,
   output logic s,
   output logic r,
   output logic set_ack,
   output logic clr_ack,
   output logic busy,
   output logic err
);

   localparam int unsigned MAX_CYC = (PULSE_CYC > GUARD_CYC) ? PULSE_CYC : GUARD_CYC;
   localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);
   localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(PULSE_CYC - 1);
   localparam logic [CNT_W-1:0] GUARD_LOAD = CNT_W'(GUARD_CYC - 1);

   state_t           state, state_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic             grant, grant_nxt;
   logic             err_q, err_nxt;
   logic             s_nxt, r_nxt;
   logic [1:0]       fb_sync;

   sr_fb_sync u_fb_sync (
      .clk (clk),
      .rst (rst),
      .d   ({q_fb, q_bar_fb}),
      .q   (fb_sync)
   );

   // State, timer, last grant and registered latch drives.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= ST_IDLE;
         cnt   <= '0;
         grant <= GRANT_CLR;
         err_q <= 1'b0;
         s     <= 1'b0;
         r     <= 1'b0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         grant <= grant_nxt;
         err_q <= err_nxt;
         s     <= s_nxt;
         r     <= r_nxt;
      end
   end

   // Next-state, arbitration, timer reload and ack decode.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      grant_nxt = grant;
      err_nxt   = err_q;
      set_ack   = 1'b0;
      clr_ack   = 1'b0;

      case (state)
         ST_IDLE: begin
            if (set_req || clr_req) begin
               // grant holds the previous winner, so a tie flips it.
               if (set_req && clr_req) begin
                  grant_nxt = ~grant;
               end else begin
                  grant_nxt = set_req ? GRANT_SET : GRANT_CLR;
               end
               state_nxt = ST_DRIVE;
               cnt_nxt   = PULSE_LOAD;
            end
         end
         ST_DRIVE: begin
            if (cnt == '0) begin
               state_nxt = ST_GUARD;
               cnt_nxt   = GUARD_LOAD;
            end else begin
               cnt_nxt = cnt - 1'b1;
            end
         end
         ST_GUARD: begin
            if (cnt == '0) begin
               state_nxt = ST_CHECK;
            end else begin
               cnt_nxt = cnt - 1'b1;
            end
         end
         ST_CHECK: begin
            if (fb_sync == fb_expected(grant)) begin
               set_ack   = (grant == GRANT_SET);
               clr_ack   = (grant == GRANT_CLR);
               state_nxt = ST_IDLE;
            end else begin
               err_nxt   = 1'b1;
               state_nxt = ST_FAULT;
            end
         end
         ST_FAULT: begin
            if (err_clr) begin
               err_nxt   = 1'b0;
               state_nxt = ST_IDLE;
            end
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase

      // Drives follow the next state so s/r are high exactly while in DRIVE;
      // a single grant bit makes s and r mutually exclusive by construction.
      s_nxt = (state_nxt == ST_DRIVE) && (grant_nxt == GRANT_SET);
      r_nxt = (state_nxt == ST_DRIVE) && (grant_nxt == GRANT_CLR);
   end

   assign busy = (state != ST_IDLE);
   assign err  = err_q;

endmodule
